// File: rtl/packet_uart_tx_if.sv
// Packet handshake bundle between the packet assembler (master) and the
// UART frame serializer (slave).
//   packet     game-state packet, valid only while pkt_valid is high
//   pkt_valid  master offers a packet
//   pkt_ready  slave can take a packet; transfer on pkt_valid & pkt_ready
interface packet_uart_tx_if #(
  parameter int PKT_BYTES = 22
);
  logic [8*PKT_BYTES-1:0] packet;
  logic                   pkt_valid;
  logic                   pkt_ready;

  modport master (output packet, output pkt_valid, input pkt_ready);
  modport slave  (input packet, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/packet_uart_tx.sv
// Serializes one game-state packet per handshake as an 8N1 UART frame:
// sync byte, PKT_BYTES payload bytes (most significant byte first) and an
// XOR checksum of the payload bytes. Bits go out LSB first; TxD idles high.
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset; abandons any frame in flight
//   bus      packet handshake (slave side): packet, pkt_valid, pkt_ready
//   TxD      registered serial output
//   busy     frame in progress
//   tx_done  one-cycle pulse after the final stop bit
module packet_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          PKT_BYTES    = 22,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  packet_uart_tx_if.slave bus,
  output logic            TxD,
  output logic            busy,
  output logic            tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(PKT_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LPAY  = IDX_W'(PKT_BYTES);
  localparam logic [IDX_W-1:0] IDX_CSUM  = IDX_W'(PKT_BYTES + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       baud_cnt;
  logic [2:0]             bit_idx;
  logic [IDX_W-1:0]       byte_idx;
  logic [8*PKT_BYTES-1:0] hold_reg;
  logic [7:0]             cur_byte;
  logic [7:0]             csum;
  logic                   ready_q;
  logic                   accept;

  assign bus.pkt_ready = ready_q;
  assign accept        = bus.pkt_valid & ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      hold_reg <= '0;
      cur_byte <= '0;
      csum     <= '0;
      ready_q  <= 1'b1;
      TxD      <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          TxD     <= 1'b1;
          ready_q <= 1'b1;
          if (accept) begin
            hold_reg <= bus.packet;
            cur_byte <= SYNC_BYTE;
            csum     <= '0;
            byte_idx <= '0;
            baud_cnt <= '0;
            ready_q  <= 1'b0;
            busy     <= 1'b1;
            TxD      <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            TxD      <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              TxD   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              cur_byte <= {1'b0, cur_byte[7:1]};
              TxD      <= cur_byte[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (byte_idx == IDX_CSUM) begin
              tx_done <= 1'b1;
              busy    <= 1'b0;
              ready_q <= 1'b1;
              TxD     <= 1'b1;
              state   <= IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              TxD      <= 1'b0;
              state    <= START;
              // Payload bytes are consumed from the top of the holding
              // register and folded into the checksum as they are loaded,
              // so the checksum is complete by the time it is needed.
              if (byte_idx == IDX_LPAY) begin
                cur_byte <= csum;
              end else begin
                cur_byte <= hold_reg[8*PKT_BYTES-1 -: 8];
                csum     <= csum ^ hold_reg[8*PKT_BYTES-1 -: 8];
                hold_reg <= hold_reg << 8;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
